// File: rtl/can_pkg.sv
// can_pkg: shared types and default timing for the CAN bit-timing controller
// Holds the bit-segment state type, default timing parameters and counter widths.
package can_pkg;
    typedef enum logic [1:0] {SYNC, SEG1, SEG2} bt_state_t;
    localparam int CAN_BRP       = 4;
    localparam int CAN_TSEG1     = 13;
    localparam int CAN_TSEG2     = 2;
    localparam int CAN_SJW       = 1;
    localparam int CAN_IDLE_BITS = 11;
    localparam int TQ_W          = 5;
    localparam int PRE_W         = 8;
endpackage

// File: rtl/can_tq_prescaler.sv
// can_tq_prescaler: divides the system clock into time quanta
// Ports: clock, reset (sync, active-high), clr (restart count at 0), tq_tick (last clock of a tq).
module can_tq_prescaler
    import can_pkg::*;
#(
    parameter int BRP = CAN_BRP
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic tq_tick
);
    logic [PRE_W-1:0] cnt;
    assign tq_tick = cnt == PRE_W'(BRP - 1);
    always_ff @(posedge clock) begin
        cnt <= (reset || clr || tq_tick) ? '0 : cnt + PRE_W'(1);
    end
endmodule

// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit-segment sequencer with hard sync, resync and bus-idle detection
// Ports: clock, reset (sync, active-high), RX (synchronised bus bit), HS_EN (hard sync allowed),
//        SP (sample strobe), RX_S (sampled bit), TX_P (SYNC start pulse), BUS_IDLE, SYNC_ERR.
// Option: CAN_TRIPLE_SAMPLE_EN takes RX_S as the majority of the last three SEG1 tq samples.
module can_bit_timing
    import can_pkg::*;
#(
    parameter int BRP       = CAN_BRP,
    parameter int TSEG1     = CAN_TSEG1,
    parameter int TSEG2     = CAN_TSEG2,
    parameter int SJW       = CAN_SJW,
    parameter int IDLE_BITS = CAN_IDLE_BITS
) (
    input  logic clock,
    input  logic reset,
    input  logic RX,
    input  logic HS_EN,
    output logic SP,
    output logic RX_S,
    output logic TX_P,
    output logic BUS_IDLE,
    output logic SYNC_ERR
);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);
    localparam logic [TQ_W-1:0] ONE  = TQ_W'(1);
    localparam logic [TQ_W-1:0] T1M1 = TQ_W'(TSEG1 - 1);
    localparam logic [TQ_W-1:0] T2   = TQ_W'(TSEG2);
    localparam logic [TQ_W-1:0] T2M1 = TQ_W'(TSEG2 - 1);
    localparam logic [TQ_W-1:0] SJ   = TQ_W'(SJW);

    if (BRP < 1 || BRP > 2**PRE_W || TSEG1 < 3 || TSEG2 < 1 || SJW < 1 || SJW > TSEG1 ||
        SJW > TSEG2 || TSEG1 + SJW > 2**TQ_W || IDLE_BITS < 1) begin : g_bad_params
        $error("can_bit_timing: illegal timing parameters");
    end

    bt_state_t state, state_n;
    logic [TQ_W-1:0] tq_cnt, cnt_n, ext, ext_n, shr, shr_n, end1, end2, e1, e2;
    logic [IDLE_W-1:0] idle_cnt;
    logic sync_done, done_n, rx_q, tq_tick, edge_det, sync_ok, hard, resync;
    logic sp_raw, sp, seg2_like, restart, err_n, tx_n, sample;

    can_tq_prescaler #(.BRP(BRP)) u_pre (
        .clock  (clock),
        .reset  (reset),
        .clr    (restart),
        .tq_tick(tq_tick)
    );

    assign end1      = T1M1 + ext;
    assign end2      = T2M1 - shr;
    assign sp_raw    = state == SEG1 && tq_tick && tq_cnt == end1;
    assign sp        = sp_raw && !hard;
    assign edge_det  = rx_q && !RX;
    assign sync_ok   = edge_det && !sync_done;
    assign hard      = sync_ok && HS_EN;
    assign resync    = sync_ok && !HS_EN && RX_S;
    // An edge in the sample-point clock already belongs to SEG2 with k=0.
    assign seg2_like = state == SEG2 || sp_raw;
    assign e1        = tq_cnt + ONE;
    assign e2        = T2 - (sp_raw ? '0 : tq_cnt);
    // A small SEG2 phase error ends the bit at once; the edge clock stands in for SYNC.
    assign restart   = hard || (resync && seg2_like && e2 <= SJ);
    assign SP        = sp && !reset;
    assign BUS_IDLE  = idle_cnt == IDLE_W'(IDLE_BITS);

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0] smp;
    always_ff @(posedge clock) begin
        if (reset)
            smp <= '1;
        else if (state == SEG1 && tq_tick && !sp_raw && tq_cnt >= end1 - TQ_W'(2))
            smp <= {smp[0], RX};
    end
    assign sample = (smp[1] & smp[0]) | (smp[1] & RX) | (smp[0] & RX);
`else
    assign sample = RX;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = tq_cnt;
        ext_n   = ext;
        shr_n   = shr;
        done_n  = sync_done;
        if (tq_tick && state == SYNC) begin
            state_n = SEG1;
            cnt_n   = '0;
        end
        if (tq_tick && state == SEG1) begin
            state_n = sp_raw ? SEG2 : SEG1;
            cnt_n   = sp_raw ? '0 : tq_cnt + ONE;
        end
        if (tq_tick && state == SEG2) begin
            state_n = (tq_cnt == end2) ? SYNC : SEG2;
            cnt_n   = (tq_cnt == end2) ? '0 : tq_cnt + ONE;
            shr_n   = (tq_cnt == end2) ? '0 : shr;
        end
        if (sp_raw) begin
            ext_n  = '0;
            done_n = 1'b0;
        end
        if (resync) begin
            done_n = 1'b1;
            if (seg2_like && e2 > SJ)
                shr_n = SJ;
            if (state == SEG1 && !sp_raw)
                ext_n = (e1 > SJ) ? SJ : e1;
        end
        if (restart) begin
            state_n = SYNC;
            cnt_n   = '0;
            ext_n   = '0;
            shr_n   = '0;
            done_n  = 1'b1;
        end
        err_n = resync && ((seg2_like && e2 > SJ) || (state == SEG1 && !sp_raw && e1 > SJ));
        tx_n  = tq_tick && state == SEG2 && tq_cnt == end2 && !restart;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SYNC;
            tq_cnt    <= '0;
            ext       <= '0;
            shr       <= '0;
            sync_done <= 1'b0;
            rx_q      <= 1'b1;
            RX_S      <= 1'b1;
            TX_P      <= 1'b0;
            SYNC_ERR  <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_n;
            tq_cnt    <= cnt_n;
            ext       <= ext_n;
            shr       <= shr_n;
            sync_done <= done_n;
            rx_q      <= RX;
            RX_S      <= sp ? sample : RX_S;
            TX_P      <= tx_n;
            SYNC_ERR  <= err_n;
            if (sp)
                idle_cnt <= !RX ? '0 : (BUS_IDLE ? idle_cnt : idle_cnt + IDLE_W'(1));
        end
    end
endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: scoreboard bench for can_bit_timing with directed RX edge scenarios
module tb_can_bit_timing;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic RX = 1'b1;
    logic HS_EN = 1'b0;
    logic SP, RX_S, TX_P, BUS_IDLE, SYNC_ERR;

    typedef struct {
        int   cyc;
        logic rx_s;
        logic idle;
        int   tx;
        logic err;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    logic err_seen = 1'b0;
    logic sp_d = 1'b0;

    can_bit_timing dut (
        .clock   (clk),
        .reset   (reset),
        .RX      (RX),
        .HS_EN   (HS_EN),
        .SP      (SP),
        .RX_S    (RX_S),
        .TX_P    (TX_P),
        .BUS_IDLE(BUS_IDLE),
        .SYNC_ERR(SYNC_ERR)
    );

    always #5 clk = ~clk;

    // cyc is 1 in the first clock after reset, matching the nominal first SP at 56.
    always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic r, input logic i, input int t, input logic e);
        exp_t x;
        x.cyc = c; x.rx_s = r; x.idle = i; x.tx = t; x.err = e;
        q.push_back(x);
    endtask

    task automatic goto(input int n);
        while (cyc != n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(input int n, input logic v);
        goto(n);
        RX = v;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        RX = 1'b1;
        HS_EN = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_sp", SP, 0);
        chk("reset_rx_s", RX_S, 1);
        chk("reset_tx_p", TX_P, 0);
        chk("reset_bus_idle", BUS_IDLE, 0);
        chk("reset_sync_err", SYNC_ERR, 0);
    endtask

    task automatic finish_scen(input int n);
        goto(n);
        chk("missing_sp", q.size(), 0);
        q.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                tx_seen = 0;
                err_seen = 1'b0;
                sp_d = 1'b0;
            end else begin
                if (TX_P) tx_seen++;
                if (SYNC_ERR) err_seen = 1'b1;
                if (sp_d) begin
                    chk("rx_s", RX_S, pend.rx_s);
                    chk("bus_idle", BUS_IDLE, pend.idle);
                    sp_d = 1'b0;
                end
                if (SP) begin
                    if (q.size() == 0) begin
                        chk("unexpected_sp", cyc, 0);
                    end else begin
                        pend = q.pop_front();
                        chk("sp_cycle", cyc, pend.cyc);
                        chk("tx_p_count", tx_seen, pend.tx);
                        chk("sync_err", err_seen, pend.err);
                        sp_d = 1'b1;
                    end
                    tx_seen = 0;
                    err_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        // Idle bus: SP every 64 clocks, BUS_IDLE from the 11th SP, then reset aborts a bit.
        do_reset();
        for (int i = 0; i < 12; i++) push(56 + 64 * i, 1'b1, i >= 10, (i == 0) ? 0 : 1, 1'b0);
        finish_scen(800);

        // Hard sync at 200: the bit restarts without TX_P, SP at 256.
        do_reset();
        HS_EN = 1'b1;
        push(56, 1'b1, 1'b0, 0, 1'b0);
        push(120, 1'b1, 1'b0, 1, 1'b0);
        push(184, 1'b1, 1'b0, 1, 1'b0);
        push(256, 1'b0, 1'b0, 1, 1'b0);
        push(320, 1'b1, 1'b0, 1, 1'b0);
        at(200, 1'b0);
        goto(201);
        HS_EN = 1'b0;
        at(260, 1'b1);
        finish_scen(330);

        // Resync 2 tq into SEG1: SEG1 grows by SJW, SP 4 clocks late; second edge ignored.
        do_reset();
        push(56, 1'b1, 1'b0, 0, 1'b0);
        push(124, 1'b0, 1'b0, 1, 1'b1);
        push(188, 1'b1, 1'b0, 1, 1'b0);
        at(78, 1'b0);
        at(90, 1'b1);
        at(100, 1'b0);
        at(130, 1'b1);
        finish_scen(200);

        // SEG2 k=1 ends the bit early; edge with RX_S=0 ignored; SEG2 k=0 shortens by SJW.
        do_reset();
        push(56, 1'b1, 1'b0, 0, 1'b0);
        push(118, 1'b0, 1'b0, 0, 1'b0);
        push(182, 1'b0, 1'b0, 1, 1'b0);
        push(246, 1'b1, 1'b0, 1, 1'b0);
        push(306, 1'b0, 1'b0, 1, 1'b1);
        at(62, 1'b0);
        at(130, 1'b1);
        at(150, 1'b0);
        at(190, 1'b1);
        at(248, 1'b0);
        finish_scen(320);

`ifdef CAN_TRIPLE_SAMPLE_EN
        // Majority of the last three SEG1 samples: 1,0,1 -> 1 then 0,0,1 -> 0.
        do_reset();
        push(56, 1'b1, 1'b0, 0, 1'b0);
        push(120, 1'b0, 1'b0, 1, 1'b0);
        at(2, 1'b0);
        at(20, 1'b1);
        at(49, 1'b0);
        at(53, 1'b1);
        at(66, 1'b0);
        at(117, 1'b1);
        finish_scen(130);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
